// File: rtl/msm_input_loader_pkg.sv
// Shared types for the MSM input loader: curve point payload, field modulus
// and the loader FSM state encoding.
package msm_input_loader_pkg;

  localparam int unsigned CURVE_W = 256;

  // Field modulus of the (toy) curve the engine runs on
  localparam logic [CURVE_W-1:0] CURVE_P = CURVE_W'(29);

  typedef struct packed {
    logic [CURVE_W-1:0] x;
    logic [CURVE_W-1:0] y;
  } curve_point_t;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_OUT   = 2'd3
  } loader_state_e;

endpackage

// File: rtl/msm_input_loader.sv
// Upstream feeder for msm_naive: packs LENGTH (point, scalar) beats into the
// G[]/x[] arrays, holds the engine in reset while loading, releases it, and
// returns the captured result R on a valid/ready port.
// Optional: define MSM_LOADER_RANGE_CHECK_EN to drop beats whose coordinates
// are not below P_MOD and raise a sticky err flag.
module msm_input_loader
  import msm_input_loader_pkg::*;
#(
  parameter int unsigned      LENGTH = 2,
  parameter int unsigned      WIDTH  = CURVE_W,
  parameter logic [WIDTH-1:0] P_MOD  = WIDTH'(CURVE_P)
) (
  input  logic                            clk,
  input  logic                            Reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [WIDTH-1:0]                in_x,
  input  logic [WIDTH-1:0]                in_y,
  input  logic [WIDTH-1:0]                in_k,
  output curve_point_t [LENGTH-1:0]       G,
  output logic [LENGTH-1:0][WIDTH-1:0]    x,
  output logic                            msm_reset,
  input  logic                            msm_done,
  input  curve_point_t                    msm_R,
  output logic                            out_valid,
  input  logic                            out_ready,
  output curve_point_t                    out_R,
  output logic [31:0]                     run_cycles,
  output logic                            err
);

  localparam int unsigned IDX_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;

  // Elaboration-time sanity check of the configuration
  if ((LENGTH < 1) || (WIDTH != CURVE_W) || (P_MOD == '0)) begin : g_param_check
    $error("msm_input_loader: invalid LENGTH/WIDTH/P_MOD");
  end

  loader_state_e                   state_q, state_d;
  logic [IDX_W-1:0]                wr_idx_q, wr_idx_d;
  curve_point_t [LENGTH-1:0]       g_q, g_d;
  logic [LENGTH-1:0][WIDTH-1:0]    x_q, x_d;
  logic                            out_valid_q, out_valid_d;
  curve_point_t                    out_r_q, out_r_d;
  logic [31:0]                     run_cycles_q, run_cycles_d;
  logic                            in_ready_q;
  logic                            msm_reset_q;
  logic                            in_range_c;

  // Coordinate range qualifier for incoming beats
`ifdef MSM_LOADER_RANGE_CHECK_EN
  logic err_q;

  assign in_range_c = (in_x < P_MOD) && (in_y < P_MOD);

  // Sticky error: an out-of-range beat was consumed and dropped in LOAD
  always_ff @(posedge clk) begin
    if (Reset) begin
      err_q <= 1'b0;
    end else if ((state_q == ST_LOAD) && in_valid && !in_range_c) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign in_range_c = 1'b1;
  assign err        = 1'b0;
`endif

  // Next-state, array write and result capture
  always_comb begin
    state_d      = state_q;
    wr_idx_d     = wr_idx_q;
    g_d          = g_q;
    x_d          = x_q;
    out_valid_d  = out_valid_q;
    out_r_d      = out_r_q;
    run_cycles_d = run_cycles_q;

    case (state_q)
      ST_LOAD: begin
        if (in_valid && in_range_c) begin
          g_d[wr_idx_q] = curve_point_t'{x: in_x, y: in_y};
          x_d[wr_idx_q] = in_k;
          if (wr_idx_q == IDX_W'(LENGTH - 1)) begin
            wr_idx_d = '0;
            state_d  = ST_START;
          end else begin
            wr_idx_d = wr_idx_q + IDX_W'(1);
          end
        end
      end
      ST_START: begin
        // Engine still in reset for one cycle with complete, stable arrays
        run_cycles_d = '0;
        state_d      = ST_RUN;
      end
      ST_RUN: begin
        if (run_cycles_q != '1) begin
          run_cycles_d = run_cycles_q + 32'd1;
        end
        if (msm_done) begin
          out_r_d     = msm_R;
          out_valid_d = 1'b1;
          state_d     = ST_OUT;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_LOAD;
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // State and output registers; handshake flags are registered decodes of the next state
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q      <= ST_LOAD;
      wr_idx_q     <= '0;
      g_q          <= '0;
      x_q          <= '0;
      out_valid_q  <= 1'b0;
      out_r_q      <= '0;
      run_cycles_q <= '0;
      in_ready_q   <= 1'b1;
      msm_reset_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      wr_idx_q     <= wr_idx_d;
      g_q          <= g_d;
      x_q          <= x_d;
      out_valid_q  <= out_valid_d;
      out_r_q      <= out_r_d;
      run_cycles_q <= run_cycles_d;
      in_ready_q   <= (state_d == ST_LOAD);
      msm_reset_q  <= (state_d != ST_RUN);
    end
  end

  assign in_ready   = in_ready_q;
  assign msm_reset  = msm_reset_q;
  assign G          = g_q;
  assign x          = x_q;
  assign out_valid  = out_valid_q;
  assign out_R      = out_r_q;
  assign run_cycles = run_cycles_q;

endmodule
